// File: rtl/translation_decode_if.sv
// Handshake and data bundle between the decoder and its SPI/SRAM peers.
interface translation_decode_if;
  logic         translation_enable;
  logic [31:0]  tot_chars;
  logic [7:0]   SPI_data_in;
  logic         SPI_read_en;
  logic [127:0] SRAM_data_in;
  logic         SRAM_read_en;
  logic [7:0]   char_index;
  logic         SPI_data_out;
  logic         SPI_write_en;
  logic         finished;

  modport master (
    output translation_enable, tot_chars,
    output SPI_data_in, SRAM_data_in,
    input  SPI_read_en, SRAM_read_en,
    input  char_index, SPI_data_out,
    input  SPI_write_en, finished
  );

  modport slave (
    input  translation_enable, tot_chars,
    input  SPI_data_in, SRAM_data_in,
    output SPI_read_en, SRAM_read_en,
    output char_index, SPI_data_out,
    output SPI_write_en, finished
  );
endinterface

// File: rtl/translation_decode.sv
// Huffman-style decoder: walks the SRAM codebook for each candidate
// path built from the SPI bit stream and emits matches serially.
module translation_decode (
  input logic                 clk,
  input logic                 rst,
  translation_decode_if.slave bus
);
  typedef enum logic [2:0] {
    INIT,
    READ_SPI_PATH,
    SPI_WAIT,
    READ_SRAM_PATH,
    COMPARE_PATHS,
    WRITE_PATH,
    FINISH
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] acc_q, acc_d;
  logic [7:0]   buf_q, buf_d;
  logic [2:0]   buf_cnt_q, buf_cnt_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [31:0]  found_q, found_d;
  logic [31:0]  tot_q, tot_d;
  logic [7:0]   idx_q, idx_d;

  logic spi_rd, sram_rd, wr_en, wr_bit, fin;
  logic hit;

  assign hit = (bus.SRAM_data_in != '0) &&
               (bus.SRAM_data_in == acc_q);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    buf_d     = buf_q;
    buf_cnt_d = buf_cnt_q;
    bit_cnt_d = bit_cnt_q;
    found_d   = found_q;
    tot_d     = tot_q;
    idx_d     = idx_q;
    spi_rd    = 1'b0;
    sram_rd   = 1'b0;
    wr_en     = 1'b0;
    wr_bit    = 1'b0;
    fin       = 1'b0;
    if (!bus.translation_enable) begin
      state_d   = INIT;
      acc_d     = 128'd1;
      buf_d     = '0;
      buf_cnt_d = '0;
      bit_cnt_d = '0;
      found_d   = '0;
      idx_d     = '0;
    end else begin
      unique case (state_q)
        INIT: begin
          tot_d     = bus.tot_chars;
          found_d   = '0;
          acc_d     = 128'd1;
          buf_cnt_d = '0;
          state_d   = (bus.tot_chars == '0) ?
                      FINISH : READ_SPI_PATH;
        end
        READ_SPI_PATH: begin
          // sentinel in bit 127: one more shift would lose it
          if (acc_q[127]) begin
            state_d = FINISH;
          end else if (buf_cnt_q == '0) begin
            spi_rd  = 1'b1;
            state_d = SPI_WAIT;
          end else begin
            acc_d     = {acc_q[126:0], buf_q[7]};
            buf_d     = {buf_q[6:0], 1'b0};
            buf_cnt_d = buf_cnt_q - 3'd1;
            idx_d     = '0;
            state_d   = READ_SRAM_PATH;
          end
        end
        SPI_WAIT: begin
          acc_d     = {acc_q[126:0], bus.SPI_data_in[7]};
          buf_d     = {bus.SPI_data_in[6:0], 1'b0};
          buf_cnt_d = 3'd7;
          idx_d     = '0;
          state_d   = READ_SRAM_PATH;
        end
        READ_SRAM_PATH: begin
          sram_rd = 1'b1;
          state_d = COMPARE_PATHS;
        end
        COMPARE_PATHS: begin
          if (hit) begin
            bit_cnt_d = '0;
            state_d   = WRITE_PATH;
          end else if (idx_q != 8'hff) begin
            idx_d   = idx_q + 8'd1;
            state_d = READ_SRAM_PATH;
          end else begin
            state_d = READ_SPI_PATH;
          end
        end
        WRITE_PATH: begin
          wr_en     = 1'b1;
          wr_bit    = idx_q[3'd7 - bit_cnt_q];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            found_d = found_q + 32'd1;
            acc_d   = 128'd1;
            state_d = (found_q + 32'd1 == tot_q) ?
                      FINISH : READ_SPI_PATH;
          end
        end
        FINISH: begin
          fin = 1'b1;
        end
        default: begin
          state_d = INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= INIT;
      acc_q     <= 128'd1;
      buf_q     <= '0;
      buf_cnt_q <= '0;
      bit_cnt_q <= '0;
      found_q   <= '0;
      tot_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      buf_q     <= buf_d;
      buf_cnt_q <= buf_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      found_q   <= found_d;
      tot_q     <= tot_d;
      idx_q     <= idx_d;
    end
  end

  assign bus.SPI_read_en  = spi_rd;
  assign bus.SRAM_read_en = sram_rd;
  assign bus.char_index   = idx_q;
  assign bus.SPI_data_out = wr_bit;
  assign bus.SPI_write_en = wr_en;
  assign bus.finished     = fin;
endmodule

// File: tb/tb_translation_decode.sv
// Scoreboard bench: SPI/SRAM responders, serial byte monitor,
// one task per scenario.
module tb_translation_decode;
  logic clk;
  logic rst;

  translation_decode_if bus ();

  translation_decode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  logic [127:0] cb [256];
  logic [7:0]   stream [$];
  logic [7:0]   exp_q [$];
  int           ptr;

  int spi_reads;
  int sram_reads;
  int writes;
  int overlap;

  // SPI and SRAM peers: data valid the cycle after the strobe
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.SPI_data_in  <= '0;
      bus.SRAM_data_in <= '0;
      ptr              <= 0;
    end else begin
      if (!bus.translation_enable)
        ptr <= 0;
      if (bus.SPI_read_en) begin
        bus.SPI_data_in <= (ptr < stream.size()) ?
                           stream[ptr] : 8'h00;
        ptr <= ptr + 1;
      end
      if (bus.SRAM_read_en)
        bus.SRAM_data_in <= cb[bus.char_index];
    end
  end

  task automatic monitor();
    logic [7:0] sh;
    logic [7:0] e;
    int         nb;
    nb = 0;
    sh = '0;
    forever begin
      @(negedge clk);
      if (bus.SPI_read_en) spi_reads++;
      if (bus.SRAM_read_en) sram_reads++;
      if (bus.SPI_read_en && bus.SRAM_read_en)
        overlap++;
      if (rst || !bus.translation_enable) begin
        nb = 0;
      end else if (bus.SPI_write_en) begin
        writes++;
        sh = {sh[6:0], bus.SPI_data_out};
        nb++;
        if (nb == 8) begin
          nb = 0;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL out_byte: got %h, expected none",
                     sh);
          end else begin
            e = exp_q.pop_front();
            if (sh !== e) begin
              fails++;
              $display("FAIL out_byte: got %h, expected %h",
                       sh, e);
            end
          end
        end
      end
    end
  endtask

  task automatic clear_cb();
    for (int i = 0; i < 256; i++) cb[i] = '0;
  endtask

  task automatic basic_cb();
    clear_cb();
    cb[8'h41] = 128'b10;
    cb[8'h42] = 128'b111;
    cb[8'h43] = 128'b110;
  endtask

  task automatic wait_fin(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.finished) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic disable_run();
    @(negedge clk);
    bus.translation_enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [12:0] o;
    rst = 1'b1;
    bus.translation_enable = 1'b0;
    bus.tot_chars = '0;
    repeat (2) @(negedge clk);
    o = {bus.SPI_read_en, bus.SRAM_read_en,
         bus.SPI_write_en, bus.SPI_data_out,
         bus.finished, bus.char_index};
    tests++;
    if (o !== 13'd0) begin
      fails++;
      $display("FAIL reset_outs: got %h, expected 0", o);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.finished !== 1'b0) begin
      fails++;
      $display("FAIL idle_fin: got %b, expected 0",
               bus.finished);
    end
  endtask

  task automatic test_basic();
    int s0, w0, o0;
    bit ok;
    basic_cb();
    stream = {8'h70};
    exp_q = {8'h41, 8'h42, 8'h43, 8'h41};
    s0 = spi_reads; w0 = writes; o0 = overlap;
    bus.tot_chars = 32'd4;
    bus.translation_enable = 1'b1;
    wait_fin(5000, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL basic_fin: got timeout, expected finished");
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL basic_left: got %0d pending, expected 0",
               exp_q.size());
    end
    tests++;
    if (spi_reads - s0 != 1) begin
      fails++;
      $display("FAIL basic_reads: got %0d, expected 1",
               spi_reads - s0);
    end
    tests++;
    if (writes - w0 != 32) begin
      fails++;
      $display("FAIL basic_writes: got %0d, expected 32",
               writes - w0);
    end
    tests++;
    if (overlap != o0) begin
      fails++;
      $display("FAIL strobe_excl: got %0d, expected %0d",
               overlap, o0);
    end
    disable_run();
    tests++;
    if (bus.finished !== 1'b0) begin
      fails++;
      $display("FAIL fin_clear: got %b, expected 0",
               bus.finished);
    end
  endtask

  task automatic test_multibyte();
    int s0;
    bit ok;
    clear_cb();
    cb[5] = 128'd1 << 10;
    stream = {8'h00, 8'h00};
    exp_q = {8'h05};
    s0 = spi_reads;
    bus.tot_chars = 32'd1;
    bus.translation_enable = 1'b1;
    wait_fin(10000, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL multi_fin: got timeout, expected finished");
    end
    tests++;
    if (spi_reads - s0 != 2) begin
      fails++;
      $display("FAIL multi_reads: got %0d, expected 2",
               spi_reads - s0);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL multi_left: got %0d pending, expected 0",
               exp_q.size());
    end
    disable_run();
  endtask

  task automatic test_zero_chars();
    int s0, r0, w0;
    basic_cb();
    stream = {8'h70};
    s0 = spi_reads; r0 = sram_reads; w0 = writes;
    bus.tot_chars = 32'd0;
    bus.translation_enable = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.finished !== 1'b1) begin
      fails++;
      $display("FAIL zero_fin: got %b, expected 1",
               bus.finished);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (spi_reads != s0 || sram_reads != r0 ||
        writes != w0) begin
      fails++;
      $display("FAIL zero_act: got %0d/%0d/%0d, expected 0/0/0",
               spi_reads - s0, sram_reads - r0, writes - w0);
    end
    disable_run();
  endtask

  task automatic test_enable_drop();
    int s0, w0;
    bit seen, ok;
    logic [11:0] o;
    basic_cb();
    stream = {8'h70};
    exp_q = {};
    bus.tot_chars = 32'd4;
    bus.translation_enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.SRAM_read_en) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL drop_scan: got timeout, expected sram read");
    end
    bus.translation_enable = 1'b0;
    @(posedge clk);
    #1;
    o = {bus.SPI_read_en, bus.SRAM_read_en,
         bus.SPI_write_en, bus.finished, bus.char_index};
    tests++;
    if (o !== 12'd0) begin
      fails++;
      $display("FAIL drop_outs: got %h, expected 0", o);
    end
    repeat (2) @(negedge clk);
    exp_q = {8'h41, 8'h42, 8'h43, 8'h41};
    s0 = spi_reads; w0 = writes;
    bus.translation_enable = 1'b1;
    wait_fin(5000, ok);
    tests++;
    if (!ok || writes - w0 != 32) begin
      fails++;
      $display("FAIL restart: got fin=%b writes=%0d, expected 1/32",
               ok, writes - w0);
    end
    tests++;
    if (spi_reads - s0 != 1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL restart_rd: got %0d/%0d, expected 1/0",
               spi_reads - s0, exp_q.size());
    end
    disable_run();
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    logic [12:0] o;
    basic_cb();
    stream = {8'h70};
    exp_q = {8'h41};
    bus.tot_chars = 32'd4;
    bus.translation_enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.SPI_write_en) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL rstw_seen: got timeout, expected write");
    end
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    o = {bus.SPI_read_en, bus.SRAM_read_en,
         bus.SPI_write_en, bus.SPI_data_out,
         bus.finished, bus.char_index};
    tests++;
    if (o !== 13'd0) begin
      fails++;
      $display("FAIL rst_mid_write: got %h, expected 0", o);
    end
    @(negedge clk);
    exp_q = {};
    bus.translation_enable = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.finished !== 1'b0 || bus.SPI_write_en !== 1'b0) begin
      fails++;
      $display("FAIL rst_after: got %b%b, expected 00",
               bus.finished, bus.SPI_write_en);
    end
  endtask

  task automatic test_unmatched();
    int s0, r0, w0;
    bit ok;
    clear_cb();
    stream = {};
    for (int i = 0; i < 16; i++) stream.push_back(8'hff);
    exp_q = {};
    s0 = spi_reads; r0 = sram_reads; w0 = writes;
    bus.tot_chars = 32'd1;
    bus.translation_enable = 1'b1;
    wait_fin(70000, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL ovf_fin: got timeout, expected finished");
    end
    tests++;
    if (sram_reads - r0 != 127 * 256) begin
      fails++;
      $display("FAIL ovf_scan: got %0d, expected %0d",
               sram_reads - r0, 127 * 256);
    end
    tests++;
    if (spi_reads - s0 != 16) begin
      fails++;
      $display("FAIL ovf_reads: got %0d, expected 16",
               spi_reads - s0);
    end
    tests++;
    if (writes != w0) begin
      fails++;
      $display("FAIL ovf_writes: got %0d, expected 0",
               writes - w0);
    end
    disable_run();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    spi_reads = 0;
    sram_reads = 0;
    writes = 0;
    overlap = 0;
    rst = 1'b1;
    bus.translation_enable = 1'b0;
    bus.tot_chars = '0;
    clear_cb();
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_multibyte();
    test_zero_chars();
    test_enable_drop();
    test_reset_mid_write();
    test_unmatched();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
